// File: rtl/mem_router_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_router_pkg                                             |
// | Description : Shared constants for the memory router: default slave      |
// |               address windows, router state encoding, default timeout    |
// |               and a select-width helper.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package mem_router_pkg;

  // Default slave ordering: 0 ram, 1 tim, 2 clic, 3 clint, 4 uart, 5 rom.
  localparam int          c_default_num_slaves = 6;

  localparam logic [31:0] c_ram_base   = 32'h8000_0000;
  localparam logic [31:0] c_ram_top    = 32'h8001_0000;
  localparam logic [31:0] c_tim_base   = 32'h4000_0000;
  localparam logic [31:0] c_tim_top    = 32'h4000_4000;
  localparam logic [31:0] c_clic_base  = 32'h0C00_0000;
  localparam logic [31:0] c_clic_top   = 32'h0C01_0000;
  localparam logic [31:0] c_clint_base = 32'h0200_0000;
  localparam logic [31:0] c_clint_top  = 32'h0201_0000;
  localparam logic [31:0] c_uart_base  = 32'h1000_0000;
  localparam logic [31:0] c_uart_top   = 32'h1000_1000;
  localparam logic [31:0] c_rom_base   = 32'h0000_0000;
  localparam logic [31:0] c_rom_top    = 32'h0001_0000;

  // Packed so that slave i occupies bits [i*32 +: 32].
  localparam logic [c_default_num_slaves*32-1:0] c_default_base =
    {c_rom_base, c_uart_base, c_clint_base, c_clic_base, c_tim_base, c_ram_base};
  localparam logic [c_default_num_slaves*32-1:0] c_default_top =
    {c_rom_top, c_uart_top, c_clint_top, c_clic_top, c_tim_top, c_ram_top};

  localparam int c_default_timeout = 255;

  // Router state encoding.
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_busy  = 2'd1;
  localparam logic [1:0] c_st_error = 2'd2;

  // Width of a slave index; at least one bit even for a single slave.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : mem_router_pkg
`default_nettype wire

// File: rtl/mem_router_addr_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : addr_decode                                                |
// | Description : Combinational priority decoder. Matches an address        |
// |               against per-slave [base, top) windows; the lowest-index    |
// |               matching window wins. Returns hit, index and window base.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module addr_decode #(
  parameter int NUM_SLAVES = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_WIDTH  = 3,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_TOP  = '0
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_hit,
  output logic [SEL_WIDTH-1:0]  o_index,
  output logic [ADDR_WIDTH-1:0] o_base
);

  // Scan from the highest index down so the lowest matching index is the
  // last assignment and therefore has priority.
  always_comb begin
    o_hit   = 1'b0;
    o_index = '0;
    o_base  = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((i_addr >= SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
          (i_addr <  SLAVE_TOP[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        o_hit   = 1'b1;
        o_index = SEL_WIDTH'(i);
        o_base  = SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

endmodule : addr_decode
`default_nettype wire

// File: rtl/mem_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_router                                                 |
// | Description : Single-master, N-slave memory router. Decodes each request |
// |               against per-slave windows, forwards a one-cycle request    |
// |               with the window base stripped, returns only the selected   |
// |               slave's response, and synthesises error responses for      |
// |               unmapped addresses and for slaves that never answer.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_router
  import mem_router_pkg::*;
#(
  parameter int NUM_SLAVES = c_default_num_slaves,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = c_default_base,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_TOP  = c_default_top,
  parameter int TIMEOUT = c_default_timeout
) (
  input  logic                         clock,
  input  logic                         reset,
  // master side
  input  logic                         memory_valid,
  input  logic                         memory_instr,
  input  logic [ADDR_WIDTH-1:0]        memory_addr,
  input  logic [DATA_WIDTH-1:0]        memory_wdata,
  input  logic [DATA_WIDTH/8-1:0]      memory_wstrb,
  output logic [DATA_WIDTH-1:0]        memory_rdata,
  output logic                         memory_error,
  output logic                         memory_ready,
  // slave side
  output logic [NUM_SLAVES-1:0]        slave_valid,
  output logic                         slave_instr,
  output logic [ADDR_WIDTH-1:0]        slave_addr,
  output logic [DATA_WIDTH-1:0]        slave_wdata,
  output logic [DATA_WIDTH/8-1:0]      slave_wstrb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_rdata,
  input  logic [NUM_SLAVES-1:0]        slave_ready,
  // status
  output logic                         decode_error,
  output logic                         timeout_error,
  output logic                         protocol_error
);

  localparam int         c_sel_width   = sel_width(NUM_SLAVES);
  // Last count value before the timeout response is issued.
  localparam logic [7:0] c_count_limit = 8'(TIMEOUT - 1);

  logic [1:0]             r_state;
  logic [c_sel_width-1:0] r_sel;
  logic [7:0]             r_count;
  logic                   r_protocol_error;

  logic                   w_hit;
  logic [c_sel_width-1:0] w_index;
  logic [ADDR_WIDTH-1:0]  w_base;
  logic                   w_idle;
  logic                   w_busy;
  logic                   w_err_state;
  logic                   w_accept;
  logic                   w_sel_ready;
  logic [DATA_WIDTH-1:0]  w_sel_rdata;
  logic                   w_timeout;

  addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SEL_WIDTH  (c_sel_width),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_TOP  (SLAVE_TOP)
  ) u_addr_decode (
    .i_addr  (memory_addr),
    .o_hit   (w_hit),
    .o_index (w_index),
    .o_base  (w_base)
  );

  assign w_idle      = (r_state == c_st_idle);
  assign w_busy      = (r_state == c_st_busy);
  assign w_err_state = (r_state == c_st_error);

  // A request is only forwarded from IDLE; held off entirely during reset.
  assign w_accept = reset && w_idle && memory_valid && w_hit;

  // Select the latched slave's ready and read data.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel == c_sel_width'(i)) begin
        w_sel_ready = slave_ready[i];
        w_sel_rdata = slave_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A ready arriving in the limit cycle beats the timeout.
  assign w_timeout = w_busy && !w_sel_ready && (r_count == c_count_limit);

  // One-hot request pulse to the decoded slave.
  always_comb begin
    slave_valid = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      slave_valid[i] = w_accept && (w_index == c_sel_width'(i));
    end
  end

  // Broadcast request fields; unmapped addresses pass through unchanged.
  assign slave_instr = memory_instr;
  assign slave_wdata = memory_wdata;
  assign slave_wstrb = memory_wstrb;
  assign slave_addr  = w_hit ? (memory_addr - w_base) : memory_addr;

  // Response path back to the master.
  assign memory_ready  = (w_busy && w_sel_ready) || w_timeout || w_err_state;
  assign memory_error  = w_timeout || w_err_state;
  assign memory_rdata  = (w_busy && w_sel_ready) ? w_sel_rdata : '0;
  assign decode_error  = w_err_state;
  assign timeout_error = w_timeout;
  assign protocol_error = r_protocol_error;

  // Router state, selected slave and cycle counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
      r_sel   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (memory_valid) begin
            if (w_hit) begin
              r_sel   <= w_index;
              r_count <= '0;
              r_state <= c_st_busy;
            end else begin
              r_state <= c_st_error;
            end
          end
        end
        c_st_busy: begin
          if (w_sel_ready || w_timeout) begin
            r_state <= c_st_idle;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        c_st_error: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // Sticky flag for a request arriving while a transaction is in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_protocol_error <= 1'b0;
    end else if (memory_valid && !w_idle) begin
      r_protocol_error <= 1'b1;
    end
  end

endmodule : mem_router
`default_nettype wire

// File: tb/tb_mem_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_router                                              |
// | Description : Self-checking bench for mem_router. Directed scenarios     |
// |               plus randomized transactions compared against a           |
// |               transaction-level reference model.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_router;

  localparam int NS = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam logic [NS*AW-1:0] c_bases = {32'h2000_0000, 32'h1000_0000};
  localparam logic [NS*AW-1:0] c_tops  = {32'h2000_0100, 32'h1001_0000};

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              memory_valid = 1'b0;
  logic              memory_instr = 1'b0;
  logic [AW-1:0]     memory_addr  = '0;
  logic [DW-1:0]     memory_wdata = '0;
  logic [DW/8-1:0]   memory_wstrb = '0;
  logic [DW-1:0]     memory_rdata;
  logic              memory_error;
  logic              memory_ready;
  logic [NS-1:0]     slave_valid;
  logic              slave_instr;
  logic [AW-1:0]     slave_addr;
  logic [DW-1:0]     slave_wdata;
  logic [DW/8-1:0]   slave_wstrb;
  logic [NS*DW-1:0]  slave_rdata = '0;
  logic [NS-1:0]     slave_ready = '0;
  logic              decode_error;
  logic              timeout_error;
  logic              protocol_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] win_base [NS];
  logic [31:0] win_top  [NS];

  mem_router #(
    .NUM_SLAVES (NS),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .SLAVE_BASE (c_bases),
    .SLAVE_TOP  (c_tops),
    .TIMEOUT    (TO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .memory_valid   (memory_valid),
    .memory_instr   (memory_instr),
    .memory_addr    (memory_addr),
    .memory_wdata   (memory_wdata),
    .memory_wstrb   (memory_wstrb),
    .memory_rdata   (memory_rdata),
    .memory_error   (memory_error),
    .memory_ready   (memory_ready),
    .slave_valid    (slave_valid),
    .slave_instr    (slave_instr),
    .slave_addr     (slave_addr),
    .slave_wdata    (slave_wdata),
    .slave_wstrb    (slave_wstrb),
    .slave_rdata    (slave_rdata),
    .slave_ready    (slave_ready),
    .decode_error   (decode_error),
    .timeout_error  (timeout_error),
    .protocol_error (protocol_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference decode: first window (lowest index) holding the address.
  task automatic ref_decode(input logic [31:0] a, output bit hit, output int idx,
                            output logic [31:0] off);
    hit = 1'b0;
    idx = 0;
    off = a;
    for (int i = 0; i < NS; i++) begin
      if (!hit && a >= win_base[i] && a < win_top[i]) begin
        hit = 1'b1;
        idx = i;
        off = a - win_base[i];
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int w;
    w = $urandom_range(0, NS - 1);
    case ($urandom_range(0, 5))
      0, 1:    return win_base[w] + ($urandom % (win_top[w] - win_base[w]));
      2:       return ($urandom_range(0, 1) == 0) ? win_base[w] : win_top[w] - 1;
      3:       return ($urandom_range(0, 1) == 0) ? win_top[w] : win_base[w] - 1;
      4:       return $urandom;
      default: return 32'h3000_0000 + ($urandom % 32'h100);
    endcase
  endfunction

  // One complete transaction. lat = cycle after the request in which the
  // selected slave pulses ready (0 = never). noise = other slaves pulse
  // ready randomly. poke = second request one cycle after the first.
  task automatic do_txn(input logic [31:0] addr, input logic [3:0] wstrb, input int lat,
                        input logic [31:0] data, input bit noise, input bit poke);
    bit          hit;
    bit          is_to;
    int          idx;
    int          resp;
    int          last;
    logic [31:0] off;
    logic [31:0] wd;
    logic        ins;
    ref_decode(addr, hit, idx, off);
    if (!hit)                       resp = 1;
    else if (lat != 0 && lat <= TO) resp = lat;
    else                            resp = TO;
    is_to = hit && (resp == TO) && (lat != TO);
    last  = (hit && lat > resp) ? lat : resp;
    wd    = $urandom;
    ins   = 1'($urandom_range(0, 1));

    memory_valid = 1'b1;
    memory_addr  = addr;
    memory_wdata = wd;
    memory_wstrb = wstrb;
    memory_instr = ins;
    slave_ready  = '0;
    @(negedge clock);
    check("req_slave_valid", 64'(slave_valid), hit ? 64'(1 << idx) : 64'd0);
    check("req_slave_addr", 64'(slave_addr), 64'(off));
    check("req_bcast", {slave_instr, slave_wstrb, slave_wdata}, {ins, wstrb, wd});
    check("req_no_resp", {memory_ready, memory_error, decode_error, timeout_error}, 64'd0);

    for (int k = 1; k <= last; k++) begin
      @(posedge clock);
      #1;
      memory_valid = poke && (k == 1);
      if (poke && k == 1) memory_addr = win_base[NS-1];
      slave_ready = '0;
      for (int j = 0; j < NS; j++) slave_rdata[j*DW +: DW] = $urandom;
      for (int j = 0; j < NS; j++) begin
        if (noise && (!hit || j != idx)) slave_ready[j] = 1'($urandom_range(0, 1));
      end
      if (hit && k == lat) begin
        slave_ready[idx]            = 1'b1;
        slave_rdata[idx*DW +: DW]   = data;
      end
      @(negedge clock);
      if (poke && k == 1) check("poke_slave_valid", 64'(slave_valid), 64'd0);
      if (k == resp) begin
        check("resp_flags", {memory_ready, memory_error, decode_error, timeout_error},
              {1'b1, !hit || is_to, !hit, is_to});
        check("resp_rdata", 64'(memory_rdata), (!hit || is_to) ? 64'd0 : 64'(data));
      end else begin
        check("quiet_flags", {memory_ready, memory_error, decode_error, timeout_error}, 64'd0);
      end
    end
    @(posedge clock);
    #1;
    memory_valid = 1'b0;
    slave_ready  = '0;
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      win_base[i] = c_bases[i*AW +: AW];
      win_top[i]  = c_tops[i*AW +: AW];
    end

    // Reset state: request held off, all responses quiet.
    memory_valid = 1'b1;
    memory_addr  = 32'h2000_0000;
    slave_ready  = '1;
    @(negedge clock);
    check("rst_slave_valid", 64'(slave_valid), 64'd0);
    check("rst_flags", {memory_ready, memory_error, decode_error, timeout_error, protocol_error}, 64'd0);
    check("rst_rdata", 64'(memory_rdata), 64'd0);
    @(posedge clock);
    #1;
    memory_valid = 1'b0;
    slave_ready  = '0;
    reset        = 1'b1;
    @(posedge clock);
    #1;

    // Directed scenarios.
    do_txn(32'h2000_0044, 4'h0, 3, 32'hCAFE_F00D, 1'b0, 1'b0);
    do_txn(32'h3000_0000, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    do_txn(32'h1000_0000, 4'h0, 20, 32'h5555_AAAA, 1'b0, 1'b0);
    do_txn(32'h1000_0010, 4'h0, 5, 32'h0000_1234, 1'b1, 1'b0);
    do_txn(32'h2000_00FF, 4'h3, TO, 32'h0BAD_CAFE, 1'b1, 1'b0);
    do_txn(32'h2000_0100, 4'h0, 2, 32'h1111_1111, 1'b1, 1'b0);
    do_txn(32'h0FFF_FFFF, 4'h1, 2, 32'h2222_2222, 1'b0, 1'b0);
    do_txn(32'h1000_FFFF, 4'h0, TO + 1, 32'h3333_3333, 1'b0, 1'b0);
    do_txn(32'h1000_0004, 4'h0, 1, 32'h4444_4444, 1'b1, 1'b0);
    check("no_protocol_error", 64'(protocol_error), 64'd0);

    // Randomized transactions.
    for (int t = 0; t < 150; t++) begin
      do_txn(rand_addr(), 4'($urandom), $urandom_range(0, TO + 6), $urandom,
             1'($urandom_range(0, 1)), 1'b0);
    end
    check("rand_no_protocol_error", 64'(protocol_error), 64'd0);

    // Request during BUSY, then during ERROR: sticky protocol error.
    do_txn(32'h1000_0100, 4'h0, 4, 32'h6666_6666, 1'b0, 1'b1);
    check("protocol_set", 64'(protocol_error), 64'd1);
    do_txn(32'h2000_0000, 4'h0, 2, 32'h7777_7777, 1'b0, 1'b0);
    check("protocol_sticky", 64'(protocol_error), 64'd1);
    do_txn(32'h5000_0000, 4'h0, 0, 32'h0, 1'b0, 1'b1);
    check("protocol_still", 64'(protocol_error), 64'd1);

    // Reset asserted in the middle of a transaction.
    memory_valid = 1'b1;
    memory_addr  = 32'h1000_0000;
    @(negedge clock);
    check("mid_slave_valid", 64'(slave_valid), 64'd1);
    @(posedge clock);
    #1;
    memory_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset        = 1'b0;
    memory_valid = 1'b1;
    memory_addr  = 32'h2000_0000;
    slave_ready  = '1;
    @(negedge clock);
    check("mid_rst_slave_valid", 64'(slave_valid), 64'd0);
    check("mid_rst_flags", {memory_ready, memory_error, decode_error, timeout_error, protocol_error}, 64'd0);
    check("mid_rst_rdata", 64'(memory_rdata), 64'd0);
    @(posedge clock);
    #1;
    reset        = 1'b1;
    memory_valid = 1'b0;
    slave_ready  = '0;
    @(posedge clock);
    #1;
    do_txn(32'h2000_0000, 4'h0, 2, 32'h8888_9999, 1'b0, 1'b0);
    check("post_rst_protocol", 64'(protocol_error), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_router
`default_nettype wire
